// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants and helpers for the CLA adder datapath
package cla_pkg;

  // Bit width of one carry-look-ahead slice
  localparam int CLA_SLICE_W = 4;

  // Operation select encoding for the sub input
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Largest positive two's-complement value of a w-bit word
  function automatic logic [63:0] SAT_MAX(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value of a w-bit word
  function automatic logic [63:0] SAT_MIN(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/cla4.sv
// rtl/cla4.sv - 4-bit carry-look-ahead adder slice
module cla4
  import cla_pkg::*;
(
  input  logic [CLA_SLICE_W-1:0] a,
  input  logic [CLA_SLICE_W-1:0] b,
  input  logic                   cin,
  output logic [CLA_SLICE_W-1:0] sum,
  output logic                   cout
);

  logic [CLA_SLICE_W-1:0] g;
  logic [CLA_SLICE_W-1:0] p;
  logic [CLA_SLICE_W:0]   c;

  // Generate/propagate terms and fully flattened look-ahead carries
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[CLA_SLICE_W-1:0];
    cout = c[CLA_SLICE_W];
  end

endmodule

// File: rtl/cla16_addsub_pipe.sv
// rtl/cla16_addsub_pipe.sv - two-stage pipelined CLA add/sub with valid/ready streams (optional CLA_SATURATION_EN)
module cla16_addsub_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int HALF = WIDTH / 2;
  localparam int NS   = HALF / CLA_SLICE_W;

`ifdef CLA_SATURATION_EN
  localparam logic [63:0] SAT_MAX_L = SAT_MAX(WIDTH);
  localparam logic [63:0] SAT_MIN_L = SAT_MIN(WIDTH);
`endif

  // Stage 1 registers: resolved low half plus raw upper operands
  logic            s1_valid;
  logic [HALF-1:0] s1_sum_lo;
  logic            s1_carry;
  logic [HALF-1:0] s1_a_hi;
  logic [HALF-1:0] s1_b_hi;
  logic            s1_sub;

  logic s1_load;
  logic s2_load;

  // Stage 1 combinational datapath
  logic [HALF-1:0] b_lo_eff;
  logic [HALF-1:0] sum_lo;
  logic [NS:0]     c_lo;

  // Stage 2 combinational datapath
  logic [HALF-1:0]  b_hi_eff;
  logic [HALF-1:0]  sum_hi;
  logic [NS:0]      c_hi;
  logic [WIDTH-1:0] raw_sum;
  logic             ovf_n;
  logic [WIDTH-1:0] result_n;

  // A full pipe still accepts when the output drains on this same edge
  assign in_ready = !s1_valid || !out_valid || out_ready;
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_valid && (!out_valid || out_ready);

  // Subtract as A + ~B + 1: invert B and inject sub as the low carry-in
  assign b_lo_eff = (sub == OP_ADD) ? b[HALF-1:0] : ~b[HALF-1:0];
  assign c_lo[0]  = (sub == OP_SUB);

  for (genvar i = 0; i < NS; i++) begin : g_lo
    cla4 u_slice (
      .a    (a[i*CLA_SLICE_W +: CLA_SLICE_W]),
      .b    (b_lo_eff[i*CLA_SLICE_W +: CLA_SLICE_W]),
      .cin  (c_lo[i]),
      .sum  (sum_lo[i*CLA_SLICE_W +: CLA_SLICE_W]),
      .cout (c_lo[i+1])
    );
  end

  // Upper B is held raw in stage 1; inversion is applied here from the registered op
  assign b_hi_eff = (s1_sub == OP_SUB) ? ~s1_b_hi : s1_b_hi;
  assign c_hi[0]  = s1_carry;

  for (genvar i = 0; i < NS; i++) begin : g_hi
    cla4 u_slice (
      .a    (s1_a_hi[i*CLA_SLICE_W +: CLA_SLICE_W]),
      .b    (b_hi_eff[i*CLA_SLICE_W +: CLA_SLICE_W]),
      .cin  (c_hi[i]),
      .sum  (sum_hi[i*CLA_SLICE_W +: CLA_SLICE_W]),
      .cout (c_hi[i+1])
    );
  end

  // Signed overflow: operands agree in sign but the sum does not
  always_comb begin
    raw_sum  = {sum_hi, s1_sum_lo};
    ovf_n    = (s1_a_hi[HALF-1] == b_hi_eff[HALF-1]) && (sum_hi[HALF-1] != s1_a_hi[HALF-1]);
    result_n = raw_sum;
`ifdef CLA_SATURATION_EN
    if (ovf_n) begin
      result_n = s1_a_hi[HALF-1] ? SAT_MIN_L[WIDTH-1:0] : SAT_MAX_L[WIDTH-1:0];
    end
`endif
  end

  // Stage 1 register: load on accept, otherwise empty when drained into stage 2
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sum_lo <= '0;
      s1_carry  <= 1'b0;
      s1_a_hi   <= '0;
      s1_b_hi   <= '0;
      s1_sub    <= OP_ADD;
    end else if (s1_load) begin
      s1_valid  <= 1'b1;
      s1_sum_lo <= sum_lo;
      s1_carry  <= c_lo[NS];
      s1_a_hi   <= a[WIDTH-1:HALF];
      s1_b_hi   <= b[WIDTH-1:HALF];
      s1_sub    <= sub;
    end else if (s2_load) begin
      s1_valid  <= 1'b0;
    end
  end

  // Stage 2 register: holds result and flags until the consumer takes them
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      result    <= result_n;
      cout      <= c_hi[NS];
      ovf       <= ovf_n;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cla16_addsub_pipe.sv
// tb/tb_cla16_addsub_pipe.sv - directed self-checking bench for cla16_addsub_pipe
module tb_cla16_addsub_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        cout;
  logic        ovf;

  int total;
  int bad;

`ifdef CLA_SATURATION_EN
  localparam logic [15:0] EXP_POS_OVF = 16'h7FFF;
  localparam logic [15:0] EXP_NEG_OVF = 16'h8000;
`else
  localparam logic [15:0] EXP_POS_OVF = 16'h8000;
  localparam logic [15:0] EXP_NEG_OVF = 16'h7FFF;
`endif

  cla16_addsub_pipe #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic sv, input logic [15:0] exp_r, input logic exp_c,
                          input logic exp_o);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = av;
    b = bv;
    sub = sv;
    #1;
    chk({tag, "_rdy"}, {15'd0, in_ready}, 16'd1);
    step();
    in_valid = 1'b0;
    a = 16'hDEAD;
    b = 16'hBEEF;
    chk({tag, "_lat1"}, {15'd0, out_valid}, 16'd0);
    step();
    chk({tag, "_vld"}, {15'd0, out_valid}, 16'd1);
    chk({tag, "_res"}, result, exp_r);
    chk({tag, "_cout"}, {15'd0, cout}, {15'd0, exp_c});
    chk({tag, "_ovf"}, {15'd0, ovf}, {15'd0, exp_o});
    step();
    chk({tag, "_drain"}, {15'd0, out_valid}, 16'd0);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_result", result, 16'h0000);
    chk("rst_cout", {15'd0, cout}, 16'd0);
    chk("rst_ovf", {15'd0, ovf}, 16'd0);
    chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
    step();

    send_one("add_1_1",    16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    send_one("add_ff_1",   16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    send_one("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    send_one("add_povf",   16'h7FFF, 16'h0001, 1'b0, EXP_POS_OVF, 1'b0, 1'b1);
    send_one("sub_novf",   16'h8000, 16'h0001, 1'b1, EXP_NEG_OVF, 1'b1, 1'b1);
    send_one("sub_0_1",    16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    send_one("sub_5_3",    16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0);
    send_one("add_mix",    16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    send_one("sub_8k_8k",  16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Backpressure: four beats offered back-to-back while the consumer stalls
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sub       = 1'b0;
    a = 16'h0010; b = 16'h0001;
    #1;
    chk("bp_rdy_b0", {15'd0, in_ready}, 16'd1);
    step();
    a = 16'h0020; b = 16'h0002;
    #1;
    chk("bp_rdy_b1", {15'd0, in_ready}, 16'd1);
    step();
    a = 16'h0030; b = 16'h0003;
    #1;
    chk("bp_full_rdy", {15'd0, in_ready}, 16'd0);
    chk("bp_full_vld", {15'd0, out_valid}, 16'd1);
    chk("bp_full_res", result, 16'h0011);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("bp_hold_rdy", {15'd0, in_ready}, 16'd0);
      chk("bp_hold_res", result, 16'h0011);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", {15'd0, in_ready}, 16'd1);
    step();
    a = 16'h0040; b = 16'h0004;
    #1;
    chk("bp_out1_vld", {15'd0, out_valid}, 16'd1);
    chk("bp_out1_res", result, 16'h0022);
    chk("bp_b3_rdy", {15'd0, in_ready}, 16'd1);
    step();
    in_valid = 1'b0;
    chk("bp_out2_vld", {15'd0, out_valid}, 16'd1);
    chk("bp_out2_res", result, 16'h0033);
    step();
    chk("bp_out3_vld", {15'd0, out_valid}, 16'd1);
    chk("bp_out3_res", result, 16'h0044);
    step();
    chk("bp_empty", {15'd0, out_valid}, 16'd0);

    // Reset with both stages occupied discards everything
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a = 16'h0100; b = 16'h0001;
    step();
    a = 16'h0200; b = 16'h0002;
    step();
    in_valid = 1'b0;
    chk("rstfull_rdy_pre", {15'd0, in_ready}, 16'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstfull_vld", {15'd0, out_valid}, 16'd0);
    chk("rstfull_rdy", {15'd0, in_ready}, 16'd1);
    chk("rstfull_res", result, 16'h0000);
    out_ready = 1'b1;
    step();
    chk("rstfull_nopart1", {15'd0, out_valid}, 16'd0);
    step();
    chk("rstfull_nopart2", {15'd0, out_valid}, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
